// File: rtl/ppm_watchdog_reset.sv
// Multi-channel PPM loss watchdog: each armed channel emits a fixed-width active-low reset pulse after PPM silence.
// Optional macro PPM_EDGE_DETECT_EN: only rising edges of ppm count as activity (default: ppm level).
module ppm_watchdog_reset #(
  parameter int NUM_CH        = 4,
  parameter int TICK_DIV      = 125,
  parameter int TIMEOUT_TICKS = 16,
  parameter int RST_PULSE     = 4,
  parameter int CNT_W         = 8
) (
  input  logic                      clk1m,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         enable,
  input  logic [NUM_CH-1:0]         ppm,
  input  logic                      clr_cnt,
  output logic [NUM_CH-1:0]         auto_reset_n,
  output logic                      any_reset_n,
  output logic [NUM_CH-1:0]         armed,
  output logic [NUM_CH*CNT_W-1:0]   timeout_cnt
);

  localparam int SUB_W   = (TICK_DIV > 1)      ? $clog2(TICK_DIV)      : 1;
  localparam int TICK_W  = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam int PULSE_W = (RST_PULSE > 1)     ? $clog2(RST_PULSE)     : 1;

  localparam logic [SUB_W-1:0]   SUB_LAST   = SUB_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TIMEOUT_TICKS - 1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_PULSE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RESET = 2'd2
  } state_e;

  state_e             state_q [NUM_CH];
  state_e             state_d [NUM_CH];
  logic [SUB_W-1:0]   sub_q   [NUM_CH];
  logic [SUB_W-1:0]   sub_d   [NUM_CH];
  logic [TICK_W-1:0]  tick_q  [NUM_CH];
  logic [TICK_W-1:0]  tick_d  [NUM_CH];
  logic [PULSE_W-1:0] pulse_q [NUM_CH];
  logic [PULSE_W-1:0] pulse_d [NUM_CH];
  logic [CNT_W-1:0]   cnt_q   [NUM_CH];
  logic [CNT_W-1:0]   cnt_d   [NUM_CH];
  logic [NUM_CH-1:0]  rst_n_q;
  logic [NUM_CH-1:0]  rst_n_d;
  logic [NUM_CH-1:0]  timeout_hit;
  logic [NUM_CH-1:0]  ev;

`ifdef PPM_EDGE_DETECT_EN
  // Previous-cycle copy of ppm; a stuck-high input produces no events and so times out.
  logic [NUM_CH-1:0] ppm_dly_q;
  logic [NUM_CH-1:0] ppm_dly_d;

  always_comb begin
    ppm_dly_d = ppm;
    ev        = ppm & ~ppm_dly_q;
  end

  always_ff @(posedge clk1m) begin
    if (!reset_n) ppm_dly_q <= '0;
    else          ppm_dly_q <= ppm_dly_d;
  end
`else
  always_comb begin
    ev = ppm;
  end
`endif

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    timeout_hit = '0;
    rst_n_d     = rst_n_q;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      sub_d[i]   = sub_q[i];
      tick_d[i]  = tick_q[i];
      pulse_d[i] = pulse_q[i];

      if (!enable[i]) begin
        state_d[i] = S_IDLE;
        sub_d[i]   = '0;
        tick_d[i]  = '0;
        pulse_d[i] = '0;
        rst_n_d[i] = 1'b1;
      end else begin
        case (state_q[i])
          S_IDLE: begin
            if (ev[i]) begin
              state_d[i] = S_ARMED;
              sub_d[i]   = '0;
              tick_d[i]  = '0;
            end
          end
          S_ARMED: begin
            // An event on the terminal-count cycle wins: the timer restarts instead of firing.
            if (ev[i]) begin
              sub_d[i]  = '0;
              tick_d[i] = '0;
            end else if (sub_q[i] == SUB_LAST && tick_q[i] == TICK_LAST) begin
              state_d[i]     = S_RESET;
              sub_d[i]       = '0;
              tick_d[i]      = '0;
              pulse_d[i]     = '0;
              rst_n_d[i]     = 1'b0;
              timeout_hit[i] = 1'b1;
            end else if (sub_q[i] == SUB_LAST) begin
              sub_d[i]  = '0;
              tick_d[i] = tick_q[i] + 1'b1;
            end else begin
              sub_d[i] = sub_q[i] + 1'b1;
            end
          end
          S_RESET: begin
            if (pulse_q[i] == PULSE_LAST) begin
              state_d[i] = S_IDLE;
              pulse_d[i] = '0;
              rst_n_d[i] = 1'b1;
            end else begin
              pulse_d[i] = pulse_q[i] + 1'b1;
            end
          end
          default: begin
            state_d[i] = S_IDLE;
            sub_d[i]   = '0;
            tick_d[i]  = '0;
            pulse_d[i] = '0;
            rst_n_d[i] = 1'b1;
          end
        endcase
      end

      if (clr_cnt)
        cnt_d[i] = '0;
      else if (timeout_hit[i] && cnt_q[i] != '1)
        cnt_d[i] = cnt_q[i] + 1'b1;
      else
        cnt_d[i] = cnt_q[i];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk1m) begin
    if (!reset_n) begin
      rst_n_q <= '1;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_IDLE;
        sub_q[i]   <= '0;
        tick_q[i]  <= '0;
        pulse_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      rst_n_q <= rst_n_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        sub_q[i]   <= sub_d[i];
        tick_q[i]  <= tick_d[i];
        pulse_q[i] <= pulse_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    armed       = '0;
    timeout_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      armed[i]                       = (state_q[i] == S_ARMED);
      timeout_cnt[i*CNT_W +: CNT_W]  = cnt_q[i];
    end
  end

  assign auto_reset_n = rst_n_q;
  assign any_reset_n  = &rst_n_q;

endmodule

// File: tb/tb_ppm_watchdog_reset.sv
// Directed bench for ppm_watchdog_reset with NUM_CH=2, TICK_DIV=4, TIMEOUT_TICKS=3 (T=12), RST_PULSE=2, CNT_W=2.
module tb_ppm_watchdog_reset;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 2;

  logic                    clk1m = 1'b0;
  logic                    reset_n;
  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH-1:0]       ppm;
  logic                    clr_cnt;
  logic [NUM_CH-1:0]       auto_reset_n;
  logic                    any_reset_n;
  logic [NUM_CH-1:0]       armed;
  logic [NUM_CH*CNT_W-1:0] timeout_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk1m = ~clk1m;

  ppm_watchdog_reset #(
    .NUM_CH(2), .TICK_DIV(4), .TIMEOUT_TICKS(3), .RST_PULSE(2), .CNT_W(2)
  ) dut (
    .clk1m(clk1m), .reset_n(reset_n), .enable(enable), .ppm(ppm), .clr_cnt(clr_cnt),
    .auto_reset_n(auto_reset_n), .any_reset_n(any_reset_n), .armed(armed), .timeout_cnt(timeout_cnt)
  );

  typedef struct {
    logic       rstn;
    logic [1:0] en;
    logic [1:0] p;
    logic       clr;
    logic [1:0] exp_auto;
    logic [1:0] exp_armed;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, take one clk1m edge, then sample outputs 1 time unit later.
  task automatic step(input logic [1:0] en, input logic [1:0] p, input logic clr, input logic rstn);
    enable  = en;
    ppm     = p;
    clr_cnt = clr;
    reset_n = rstn;
    @(posedge clk1m);
    #1;
  endtask

  task automatic check_out(input string name, input logic [1:0] e_auto, input logic [1:0] e_armed,
                           input logic [3:0] e_cnt);
    check({name, "_auto"},  32'(auto_reset_n), 32'(e_auto));
    check({name, "_any"},   32'(any_reset_n),  32'(&e_auto));
    check({name, "_armed"}, 32'(armed),        32'(e_armed));
    check({name, "_cnt"},   32'(timeout_cnt),  32'(e_cnt));
  endtask

  task automatic idle_steps(input int n, input logic [1:0] en, input logic [1:0] e_auto,
                            input logic [1:0] e_armed, input logic [3:0] e_cnt, input string name);
    for (int k = 0; k < n; k++) begin
      step(en, 2'b00, 1'b0, 1'b1);
      check_out(name, e_auto, e_armed, e_cnt);
    end
  endtask

  function automatic vec_t mk(input logic rstn, input logic [1:0] en, input logic [1:0] p, input logic clr,
                              input logic [1:0] ea, input logic [1:0] em, input logic [3:0] ec);
    vec_t v;
    v.rstn = rstn; v.en = en; v.p = p; v.clr = clr;
    v.exp_auto = ea; v.exp_armed = em; v.exp_cnt = ec;
    return v;
  endfunction

  logic [1:0] exp_sat [4];
  logic [1:0] e_auto6;
  logic [1:0] e_arm6;
  logic [3:0] e_cnt6;

  initial begin
    enable  = 2'b11;
    ppm     = 2'b00;
    clr_cnt = 1'b0;
    reset_n = 1'b0;

    // Block reset with ppm toggling, then a single ch0 event followed by silence to timeout.
    vecs.push_back(mk(1'b0, 2'b11, 2'b01, 1'b0, 2'b11, 2'b00, 4'h0));
    vecs.push_back(mk(1'b0, 2'b11, 2'b10, 1'b0, 2'b11, 2'b00, 4'h0));
    vecs.push_back(mk(1'b0, 2'b11, 2'b11, 1'b0, 2'b11, 2'b00, 4'h0));
    vecs.push_back(mk(1'b1, 2'b11, 2'b01, 1'b0, 2'b11, 2'b01, 4'h0));
    for (int e = 1; e <= 11; e++)
      vecs.push_back(mk(1'b1, 2'b11, 2'b00, 1'b0, 2'b11, 2'b01, 4'h0));
    vecs.push_back(mk(1'b1, 2'b11, 2'b00, 1'b0, 2'b10, 2'b00, 4'h1));
    vecs.push_back(mk(1'b1, 2'b11, 2'b00, 1'b0, 2'b10, 2'b00, 4'h1));
    vecs.push_back(mk(1'b1, 2'b11, 2'b00, 1'b0, 2'b11, 2'b00, 4'h1));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].p, vecs[i].clr, vecs[i].rstn);
      check_out($sformatf("vec%0d", i), vecs[i].exp_auto, vecs[i].exp_armed, vecs[i].exp_cnt);
    end

    // Period-12 events: the event lands on the terminal-count edge and must win.
    for (int p = 0; p < 4; p++) begin
      step(2'b11, 2'b01, 1'b0, 1'b1);
      check_out("t3_pulse", 2'b11, 2'b01, 4'h1);
      idle_steps(11, 2'b11, 2'b11, 2'b01, 4'h1, "t3_period12");
    end
    step(2'b11, 2'b01, 1'b0, 1'b1);
    check_out("t3_gap_arm", 2'b11, 2'b01, 4'h1);
    idle_steps(11, 2'b11, 2'b11, 2'b01, 4'h1, "t3_gap_pre");
    step(2'b11, 2'b00, 1'b0, 1'b1);
    check_out("t3_gap13_fire", 2'b10, 2'b00, 4'h2);
    step(2'b11, 2'b00, 1'b0, 1'b1);
    check_out("t3_gap13_hold", 2'b10, 2'b00, 4'h2);
    step(2'b11, 2'b00, 1'b0, 1'b1);
    check_out("t3_gap13_end", 2'b11, 2'b00, 4'h2);

    // Disable mid-pulse aborts it on the next edge; channel stays idle afterwards.
    step(2'b11, 2'b01, 1'b0, 1'b1);
    idle_steps(11, 2'b11, 2'b11, 2'b01, 4'h2, "t4_wait");
    step(2'b11, 2'b00, 1'b0, 1'b1);
    check_out("t4_fire", 2'b10, 2'b00, 4'h3);
    step(2'b10, 2'b00, 1'b0, 1'b1);
    check_out("t4_abort", 2'b11, 2'b00, 4'h3);
    step(2'b11, 2'b00, 1'b0, 1'b1);
    check_out("t4_after_abort", 2'b11, 2'b00, 4'h3);

    // clr_cnt on the timeout edge beats the increment.
    step(2'b11, 2'b01, 1'b0, 1'b1);
    idle_steps(11, 2'b11, 2'b11, 2'b01, 4'h3, "t4_clr_wait");
    step(2'b11, 2'b00, 1'b1, 1'b1);
    check_out("t4_clr_on_timeout", 2'b10, 2'b00, 4'h0);
    step(2'b11, 2'b00, 1'b0, 1'b1);
    check_out("t4_clr_hold", 2'b10, 2'b00, 4'h0);
    step(2'b11, 2'b00, 1'b0, 1'b1);
    check_out("t4_clr_end", 2'b11, 2'b00, 4'h0);

    // Four ch1 timeouts: counter saturates at 3.
    exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3};
    for (int k = 0; k < 4; k++) begin
      logic [1:0] prev;
      prev = (k == 0) ? 2'd0 : exp_sat[k-1];
      step(2'b11, 2'b10, 1'b0, 1'b1);
      check_out("t5_arm", 2'b11, 2'b10, {prev, 2'b00});
      idle_steps(11, 2'b11, 2'b11, 2'b10, {prev, 2'b00}, "t5_wait");
      step(2'b11, 2'b00, 1'b0, 1'b1);
      check_out($sformatf("t5_fire%0d", k), 2'b01, 2'b00, {exp_sat[k], 2'b00});
      step(2'b11, 2'b00, 1'b0, 1'b1);
      check_out("t5_hold", 2'b01, 2'b00, {exp_sat[k], 2'b00});
      step(2'b11, 2'b00, 1'b0, 1'b1);
      check_out("t5_end", 2'b11, 2'b00, {exp_sat[k], 2'b00});
    end

    // Simultaneous timeouts on both channels.
    step(2'b11, 2'b11, 1'b0, 1'b1);
    check_out("t5_sim_arm", 2'b11, 2'b11, 4'hC);
    idle_steps(11, 2'b11, 2'b11, 2'b11, 4'hC, "t5_sim_wait");
    step(2'b11, 2'b00, 1'b0, 1'b1);
    check_out("t5_sim_fire", 2'b00, 2'b00, 4'hD);
    step(2'b11, 2'b00, 1'b0, 1'b1);
    check_out("t5_sim_hold", 2'b00, 2'b00, 4'hD);
    step(2'b11, 2'b00, 1'b0, 1'b1);
    check_out("t5_sim_end", 2'b11, 2'b00, 4'hD);

    // Block reset in the middle of a pulse.
    step(2'b11, 2'b01, 1'b0, 1'b1);
    idle_steps(11, 2'b11, 2'b11, 2'b01, 4'hD, "t5_rst_wait");
    step(2'b11, 2'b00, 1'b0, 1'b1);
    check_out("t5_rst_fire", 2'b10, 2'b00, 4'hE);
    step(2'b11, 2'b00, 1'b0, 1'b0);
    check_out("t5_rst_mid_pulse", 2'b11, 2'b00, 4'h0);
    step(2'b11, 2'b00, 1'b0, 1'b1);
    check_out("t5_rst_after", 2'b11, 2'b00, 4'h0);

    // ppm[0] held high for 30 edges (E0..E29), then low.
    step(2'b11, 2'b01, 1'b0, 1'b1);
    check_out("t6_e0", 2'b11, 2'b01, 4'h0);
    for (int k = 1; k <= 29; k++) begin
      step(2'b11, 2'b01, 1'b0, 1'b1);
`ifdef PPM_EDGE_DETECT_EN
      e_auto6 = (k == 12 || k == 13) ? 2'b10 : 2'b11;
      e_arm6  = (k < 12) ? 2'b01 : 2'b00;
      e_cnt6  = (k >= 12) ? 4'h1 : 4'h0;
`else
      e_auto6 = 2'b11;
      e_arm6  = 2'b01;
      e_cnt6  = 4'h0;
`endif
      check_out($sformatf("t6_high_e%0d", k), e_auto6, e_arm6, e_cnt6);
    end
`ifdef PPM_EDGE_DETECT_EN
    idle_steps(12, 2'b11, 2'b11, 2'b00, 4'h1, "t6_low_no_rearm");
`else
    idle_steps(11, 2'b11, 2'b11, 2'b01, 4'h0, "t6_low_wait");
    step(2'b11, 2'b00, 1'b0, 1'b1);
    check_out("t6_fire_after_fall", 2'b10, 2'b00, 4'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
